tile_scheduler: RTL and testbench



---
 rtl/tile_scheduler.sv | 130 +++++++++++++
 tb/tb_tile_scheduler.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_scheduler.sv
// tile_scheduler: walks the screen tile by tile, issuing a clear pass, the tile's triangles,
// then a write-back request before advancing to the next tile.
module tile_scheduler #(
    parameter int TILES_X      = 20,
    parameter int TILES_Y      = 15,
    parameter int DONE_HOLDOFF = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    output logic        busy,
    output logic        frame_done,
    input  logic        tri_valid,
    input  logic        tri_last,
    input  logic        tri_null,
    output logic        tri_ready,
    output logic        rend_start,
    output logic        rend_clear,
    input  logic        rend_done,
    output logic        wb_req,
    input  logic        wb_ack,
    output logic [5:0]  tile_x,
    output logic [5:0]  tile_y,
    output logic [15:0] tile_tri_cnt
);
    localparam int HW = DONE_HOLDOFF > 0 ? $clog2(DONE_HOLDOFF + 1) : 1;
    localparam logic [HW-1:0] HOLD = HW'(DONE_HOLDOFF);
    localparam logic [5:0] XL = 6'(TILES_X - 1);
    localparam logic [5:0] YL = 6'(TILES_Y - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, CWAIT, FETCH, TWAIT, WB} state_t;

    state_t         state, state_n;
    logic [HW-1:0]  hold, hold_n;
    logic           last_q, last_n;
    logic [5:0]     x_n, y_n;
    logic [15:0]    cnt_n;
    logic           done_n;
    logic           hold_over;

    assign busy      = state != IDLE;
    assign wb_req    = state == WB;
    assign hold_over = hold == '0;

    always_comb begin
        state_n    = state;
        hold_n     = hold_over ? hold : hold - HW'(1);
        last_n     = last_q;
        x_n        = tile_x;
        y_n        = tile_y;
        cnt_n      = tile_tri_cnt;
        done_n     = 1'b0;
        tri_ready  = 1'b0;
        rend_start = 1'b0;
        rend_clear = 1'b0;
        unique case (state)
            IDLE: begin
                // a start arriving alongside the previous frame's done pulse is dropped
                if (frame_start && !frame_done) begin
                    x_n     = '0;
                    y_n     = '0;
                    state_n = CLEAR;
                end
            end
            CLEAR: begin
                if (rend_done) begin
                    rend_start = 1'b1;
                    rend_clear = 1'b1;
                    hold_n     = HOLD;
                    cnt_n      = '0;
                    state_n    = CWAIT;
                end
            end
            CWAIT: state_n = (hold_over && rend_done) ? FETCH : CWAIT;
            FETCH: begin
                if (tri_valid && rend_done) begin
                    tri_ready = 1'b1;
                    if (tri_null) begin
                        state_n = tri_last ? WB : FETCH;
                    end else begin
                        rend_start = 1'b1;
                        last_n     = tri_last;
                        cnt_n      = (tile_tri_cnt == 16'hFFFF) ? tile_tri_cnt : tile_tri_cnt + 16'd1;
                        hold_n     = HOLD;
                        state_n    = TWAIT;
                    end
                end
            end
            TWAIT: begin
                if (hold_over && rend_done)
                    state_n = last_q ? WB : FETCH;
            end
            WB: begin
                if (wb_ack) begin
                    if (tile_x == XL && tile_y == YL) begin
                        x_n     = '0;
                        y_n     = '0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        x_n     = (tile_x == XL) ? 6'd0 : tile_x + 6'd1;
                        y_n     = (tile_x == XL) ? tile_y + 6'd1 : tile_y;
                        state_n = CLEAR;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            hold         <= '0;
            last_q       <= 1'b0;
            tile_x       <= '0;
            tile_y       <= '0;
            tile_tri_cnt <= '0;
            frame_done   <= 1'b0;
        end else begin
            state        <= state_n;
            hold         <= hold_n;
            last_q       <= last_n;
            tile_x       <= x_n;
            tile_y       <= y_n;
            tile_tri_cnt <= cnt_n;
            frame_done   <= done_n;
        end
    end
endmodule

// File: tb/tb_tile_scheduler.sv
// tb_tile_scheduler: frame-level scenarios against an event-sequence reference model,
// with FIFO, renderer and write-back responders modelled in the bench.
module tb_tile_scheduler;
    localparam int TX = 3;
    localparam int TY = 2;
    localparam int NT = TX * TY;
    localparam int HO = 2;

    logic clk = 1'b0, rst = 1'b1;
    logic frame_start = 1'b0, tri_valid = 1'b0, tri_last = 1'b0, tri_null = 1'b0;
    logic rend_done = 1'b1, wb_ack = 1'b0;
    logic busy, frame_done, tri_ready, rend_start, rend_clear, wb_req;
    logic [5:0] tile_x, tile_y;
    logic [15:0] tile_tri_cnt;

    tile_scheduler #(.TILES_X(TX), .TILES_Y(TY), .DONE_HOLDOFF(HO)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .busy(busy), .frame_done(frame_done),
        .tri_valid(tri_valid), .tri_last(tri_last), .tri_null(tri_null), .tri_ready(tri_ready),
        .rend_start(rend_start), .rend_clear(rend_clear), .rend_done(rend_done),
        .wb_req(wb_req), .wb_ack(wb_ack), .tile_x(tile_x), .tile_y(tile_y), .tile_tri_cnt(tile_tri_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { bit last; bit nul; } rec_t;
    typedef struct { int kind; int x; int y; int cnt; } evt_t;
    typedef struct {
        int tris[NT];
        int rend_time;
        int wb_delay;
        bit gaps;
        bit spam;
        int exp_tri;
        int exp_wb;
    } vec_t;

    rec_t fifo[$];
    evt_t exp_q[$];
    int n_chk = 0, n_fail = 0, cyc = 0, last_start = -100;
    int rcnt = 0, wcnt = 0, vgap = 0, rend_time = 0, wb_delay = 0;
    bit gaps = 0, spam = 0, start_now = 0;
    int done_seen, n_tri_obs, n_wb_obs, first_tri_cyc, last_kind, last_x, start_cyc;
    logic s_ready = 0, s_start = 0, s_busy = 0, s_wbreq = 0, s_ack = 0;
    logic [5:0] s_x = 0, s_y = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int k, input int x, input int y, input int c);
        evt_t e;
        e.kind = k; e.x = x; e.y = y; e.cnt = c;
        exp_q.push_back(e);
    endtask

    // expected event stream: clear, each real triangle, write-back per tile in raster order, then done
    task automatic load_frame(input int tris[NT]);
        rec_t r;
        for (int t = 0; t < NT; t++) begin
            push_exp(0, t % TX, t / TX, 0);
            if (tris[t] == 0) begin
                r.last = 1'b1; r.nul = 1'b1;
                fifo.push_back(r);
            end
            for (int k = 0; k < tris[t]; k++) begin
                r.last = (k == tris[t] - 1); r.nul = 1'b0;
                fifo.push_back(r);
                push_exp(1, t % TX, t / TX, k);
            end
            push_exp(2, t % TX, t / TX, tris[t]);
        end
        push_exp(3, 0, 0, 0);
    endtask

    task automatic observe(input int kind, input int cnt);
        evt_t e;
        last_kind = kind;
        last_x = int'(tile_x);
        if (exp_q.size() == 0) begin
            check("unexpected_event", kind, -1);
            return;
        end
        e = exp_q.pop_front();
        check("event_kind", kind, e.kind);
        check("event_tile_x", int'(tile_x), e.x);
        check("event_tile_y", int'(tile_y), e.y);
        check("event_count", cnt, e.cnt);
    endtask

    task automatic sample();
        if (tri_ready) check("ready_needs_valid_and_done", int'(tri_valid && rend_done), 1);
        if (tri_ready && tri_null) check("null_record_no_start", int'(rend_start), 0);
        if (rend_start) begin
            check("start_needs_done", int'(rend_done), 1);
            check("start_spacing", int'(cyc - last_start >= HO + 1), 1);
            check("start_outside_wb", int'(wb_req), 0);
            last_start = cyc;
        end
        if (rend_start && rend_clear) observe(0, 0);
        if (rend_start && !rend_clear) begin
            check("tri_start_pops_real_record", int'(tri_ready && !tri_null), 1);
            if (first_tri_cyc < 0) first_tri_cyc = cyc;
            n_tri_obs++;
            observe(1, int'(tile_tri_cnt));
        end
        if (s_wbreq && !s_ack) begin
            check("wb_req_held", int'(wb_req), 1);
            check("wb_tile_x_stable", int'(tile_x), int'(s_x));
            check("wb_tile_y_stable", int'(tile_y), int'(s_y));
        end
        if (wb_req && !s_wbreq) begin
            n_wb_obs++;
            observe(2, int'(tile_tri_cnt));
        end
        if (frame_done) begin
            done_seen++;
            observe(3, int'(busy));
        end
        s_ready = tri_ready; s_start = rend_start; s_busy = busy;
        s_wbreq = wb_req; s_ack = wb_ack; s_x = tile_x; s_y = tile_y;
    endtask

    // advance one clock: responders react to what was seen in the cycle that just ended
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (s_ready && fifo.size() > 0) void'(fifo.pop_front());
        if (s_start) rcnt = rend_time;
        else if (rcnt > 0) rcnt--;
        rend_done = (rcnt == 0);
        if (wb_delay < 0) wb_ack = 1'b1;
        else if (s_wbreq && s_ack) begin wb_ack = 1'b0; wcnt = 0; end
        else if (s_wbreq) begin
            if (wcnt >= wb_delay) wb_ack = 1'b1;
            else wcnt++;
        end
        if (vgap > 0) vgap--;
        tri_valid = fifo.size() > 0 && vgap == 0 && (!gaps || $urandom_range(0, 3) != 0);
        tri_last = fifo.size() > 0 ? fifo[0].last : 1'b0;
        tri_null = fifo.size() > 0 ? fifo[0].nul : 1'b0;
        frame_start = start_now || (spam && s_busy);
        start_now = 0;
        @(negedge clk);
        sample();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_frame_done"}, int'(frame_done), 0);
        check({tag, "_tri_ready"}, int'(tri_ready), 0);
        check({tag, "_rend_start"}, int'(rend_start), 0);
        check({tag, "_rend_clear"}, int'(rend_clear), 0);
        check({tag, "_wb_req"}, int'(wb_req), 0);
        check({tag, "_tile_x"}, int'(tile_x), 0);
        check({tag, "_tile_y"}, int'(tile_y), 0);
        check({tag, "_tile_tri_cnt"}, int'(tile_tri_cnt), 0);
    endtask

    task automatic run_frame(input vec_t v, input int vg, input int abort_x);
        fifo.delete();
        exp_q.delete();
        rend_time = v.rend_time; wb_delay = v.wb_delay; gaps = v.gaps; spam = v.spam; vgap = vg;
        load_frame(v.tris);
        done_seen = 0; n_tri_obs = 0; n_wb_obs = 0; first_tri_cyc = -1; last_kind = -1;
        start_now = 1;
        step();
        start_cyc = cyc;
        check("busy_low_in_start_cycle", int'(busy), 0);
        step();
        check("busy_after_start", int'(busy), 1);
        if (abort_x >= 0) begin
            for (int i = 0; i < 5000 && !(last_kind == 1 && last_x == abort_x); i++) step();
            check("abort_point_reached", int'(last_kind == 1 && last_x == abort_x), 1);
            return;
        end
        for (int i = 0; i < 20000 && done_seen == 0; i++) step();
        check("frame_done_seen", done_seen, 1);
        repeat (3) step();
        check("frame_done_single_pulse", done_seen, 1);
        check("idle_after_frame", int'(busy), 0);
        check("events_all_seen", exp_q.size(), 0);
        check("fifo_drained", fifo.size(), 0);
        check("triangles_rendered", n_tri_obs, v.exp_tri);
        check("writebacks", n_wb_obs, v.exp_wb);
    endtask

    initial begin
        vec_t tbl[5];
        vec_t v;
        tbl[0].tris = '{0, 0, 0, 0, 0, 0}; tbl[0].rend_time = 0;  tbl[0].wb_delay = 0;
        tbl[0].gaps = 0; tbl[0].spam = 0; tbl[0].exp_tri = 0;  tbl[0].exp_wb = 6;
        tbl[1].tris = '{3, 0, 0, 0, 0, 0}; tbl[1].rend_time = 12; tbl[1].wb_delay = 0;
        tbl[1].gaps = 0; tbl[1].spam = 0; tbl[1].exp_tri = 3;  tbl[1].exp_wb = 6;
        tbl[2].tris = '{1, 2, 0, 4, 0, 1}; tbl[2].rend_time = 1;  tbl[2].wb_delay = -1;
        tbl[2].gaps = 0; tbl[2].spam = 0; tbl[2].exp_tri = 8;  tbl[2].exp_wb = 6;
        tbl[3].tris = '{2, 2, 2, 2, 2, 2}; tbl[3].rend_time = 3;  tbl[3].wb_delay = 50;
        tbl[3].gaps = 0; tbl[3].spam = 0; tbl[3].exp_tri = 12; tbl[3].exp_wb = 6;
        tbl[4].tris = '{1, 0, 5, 0, 0, 2}; tbl[4].rend_time = 0;  tbl[4].wb_delay = 2;
        tbl[4].gaps = 1; tbl[4].spam = 1; tbl[4].exp_tri = 8;  tbl[4].exp_wb = 6;

        #3;
        check_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_frame(tbl[i], 0, -1);

        // triangle FIFO empty-looking for a long stretch while the scheduler sits in FETCH
        v = tbl[0];
        v.tris = '{2, 1, 0, 0, 0, 0}; v.exp_tri = 3;
        run_frame(v, 35, -1);
        check("no_fetch_during_valid_gap", int'(first_tri_cyc - start_cyc >= 34), 1);

        for (int r = 0; r < 6; r++) begin
            v.exp_tri = 0;
            for (int t = 0; t < NT; t++) begin
                v.tris[t] = int'($urandom_range(0, 4));
                v.exp_tri += v.tris[t];
            end
            v.rend_time = int'($urandom_range(0, 5));
            v.wb_delay = int'($urandom_range(0, 5)) - 1;
            v.gaps = 1'($urandom_range(0, 1));
            v.spam = 1'($urandom_range(0, 1));
            v.exp_wb = NT;
            run_frame(v, 0, -1);
        end

        // abort mid-frame while waiting on a triangle in tile (1,0)
        v = tbl[1];
        v.tris = '{1, 3, 1, 0, 0, 0};
        run_frame(v, 0, 1);
        step();
        step();
        check("pre_abort_tile_x", int'(tile_x), 1);
        check("pre_abort_tri_cnt", int'(tile_tri_cnt), 1);
        check("pre_abort_busy", int'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_abort");
        fifo.delete(); exp_q.delete();
        rcnt = 0; wcnt = 0; vgap = 0; last_start = -100;
        rend_done = 1'b1; wb_ack = 1'b0; tri_valid = 1'b0; frame_start = 1'b0;
        s_ready = 0; s_start = 0; s_busy = 0; s_wbreq = 0; s_ack = 0; s_x = 0; s_y = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_frame(tbl[2], 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
